// File: rtl/trace_pkg.sv
// Shared types and defaults for the trace alignment checker.
// Observations are the (a, b) pair produced by one non-stutter step.
package trace_pkg;

  typedef struct packed {
    logic a;
    logic b;
  } obs_t;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

  function automatic logic obs_eq(
    input obs_t x,
    input obs_t y
  );
    return (x.a == y.a) && (x.b == y.b);
  endfunction

endpackage

// File: rtl/obs_fifo.sv
// Per-side observation queue with registered count.
// A push into a full queue is accepted only when a pop frees a slot.
module obs_fifo #(
  parameter int DEPTH = trace_pkg::DEF_DEPTH,
  parameter type obs_t = trace_pkg::obs_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  obs_t                     push_data,
  input  logic                     pop,
  output obs_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  obs_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_align_checker.sv
// Stutter-equivalence checker for a source/target trace pair.
// Stutter steps are dropped; remaining observations are compared in order.
module trace_align_checker
  import trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       a_src,
  input  logic                       b_src,
  input  logic                       st_src,
  input  logic                       a_tar,
  input  logic                       b_tar,
  input  logic                       st_tar,
  output logic                       mismatch,
  output logic                       overflow,
  output logic                       aligned,
  output logic [$clog2(DEPTH)+1:0]   lag,
  output logic [CNT_W-1:0]           pairs
);

  localparam int CW = $clog2(DEPTH) + 1;

  obs_t          head_src, head_tar;
  logic [CW-1:0] cnt_src, cnt_tar;
  logic          full_src, full_tar;
  logic          empty_src, empty_tar;
  logic          push_src, push_tar;
  logic          pop;
  logic          drop;

  assign push_src = en && !st_src;
  assign push_tar = en && !st_tar;
  // Pop decision uses registered occupancy, so fresh pushes wait a cycle.
  assign pop      = !empty_src && !empty_tar;
  assign drop     = !pop && ((push_src && full_src) ||
                             (push_tar && full_tar));

  obs_fifo #(.DEPTH(DEPTH), .obs_t(obs_t)) u_src (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_src),
    .push_data ('{a: a_src, b: b_src}),
    .pop       (pop),
    .head      (head_src),
    .count     (cnt_src),
    .full      (full_src),
    .empty     (empty_src)
  );

  obs_fifo #(.DEPTH(DEPTH), .obs_t(obs_t)) u_tar (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_tar),
    .push_data ('{a: a_tar, b: b_tar}),
    .pop       (pop),
    .head      (head_tar),
    .count     (cnt_tar),
    .full      (full_tar),
    .empty     (empty_tar)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
      overflow <= 1'b0;
      pairs    <= '0;
    end else begin
      if (pop && !obs_eq(head_src, head_tar)) begin
        mismatch <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop && (pairs != '1)) begin
        pairs <= pairs + CNT_W'(1);
      end
    end
  end

  assign lag     = {1'b0, cnt_src} - {1'b0, cnt_tar};
  assign aligned = empty_src && empty_tar;

endmodule

// File: tb/tb_trace_align_checker.sv
// Randomized and directed bench for trace_align_checker.
// Expected values come from queue-based trace model and fixed scenarios.
module tb_trace_align_checker;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 2;

  logic clk = 1'b0;
  logic rst_n, en;
  logic a_src, b_src, st_src;
  logic a_tar, b_tar, st_tar;
  logic mismatch, overflow, aligned;
  logic [LW-1:0] lag;
  logic [7:0] pairs;
  logic mismatch2, overflow2, aligned2;
  logic [LW-1:0] lag2;
  logic [1:0] pairs2;

  int errors = 0;
  int checks = 0;

  logic [1:0] qs[$];
  logic [1:0] qt[$];
  logic m_mis, m_ovf;
  int   m_pairs;

  always #5 clk = ~clk;

  trace_align_checker #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_src(a_src), .b_src(b_src), .st_src(st_src),
    .a_tar(a_tar), .b_tar(b_tar), .st_tar(st_tar),
    .mismatch(mismatch), .overflow(overflow), .aligned(aligned),
    .lag(lag), .pairs(pairs)
  );

  trace_align_checker #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_src(a_src), .b_src(b_src), .st_src(st_src),
    .a_tar(a_tar), .b_tar(b_tar), .st_tar(st_tar),
    .mismatch(mismatch2), .overflow(overflow2), .aligned(aligned2),
    .lag(lag2), .pairs(pairs2)
  );

  // One clock edge: drive inputs, then advance the trace model.
  task automatic tick(input logic r, input logic e,
                      input logic ss, input logic [1:0] xs,
                      input logic stt, input logic [1:0] xt);
    logic [1:0] hs, ht;
    @(negedge clk);
    rst_n = r; en = e;
    st_src = ss; {a_src, b_src} = xs;
    st_tar = stt; {a_tar, b_tar} = xt;
    @(posedge clk);
    if (!r) begin
      qs.delete(); qt.delete();
      m_mis = 0; m_ovf = 0; m_pairs = 0;
    end else begin
      if (qs.size() > 0 && qt.size() > 0) begin
        hs = qs.pop_front();
        ht = qt.pop_front();
        if (hs != ht) m_mis = 1;
        m_pairs++;
      end
      if (e && !ss) begin
        if (qs.size() < DEPTH) qs.push_back(xs);
        else m_ovf = 1;
      end
      if (e && !stt) begin
        if (qt.size() < DEPTH) qt.push_back(xt);
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mismatch, overflow, aligned} !== 3'b001 || lag !== '0 ||
        pairs !== 8'd0) begin
      errors++;
      $display("FAIL reset: mis=%b ovf=%b al=%b lag=%0d pairs=%0d want 0 0 1 0 0",
               mismatch, overflow, aligned, lag, pairs);
    end
  endtask

  task automatic test_lockstep();
    logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, seq[i], 1'b0, seq[i]);
      if (i == 0) begin
        checks++;
        if (aligned !== 1'b0 || lag !== '0 || pairs !== 8'd0) begin
          errors++;
          $display("FAIL lockstep_first: al=%b lag=%0d pairs=%0d want 0 0 0",
                   aligned, lag, pairs);
        end
      end
    end
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    checks++;
    if (pairs !== 8'd5 || mismatch !== 1'b0 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL lockstep_end: pairs=%0d mis=%b al=%b want 5 0 1",
               pairs, mismatch, aligned);
    end
    checks++;
    if (pairs2 !== 2'd3) begin
      errors++;
      $display("FAIL saturation: pairs=%0d want 3", pairs2);
    end
  endtask

  task automatic test_stutter_skew();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00);
    checks++;
    if (lag !== LW'(1)) begin
      errors++;
      $display("FAIL skew_peak: lag=%0d want 1", lag);
    end
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01);
    checks++;
    if (lag !== '0 || pairs !== 8'd0) begin
      errors++;
      $display("FAIL skew_equal: lag=%0d pairs=%0d want 0 0", lag, pairs);
    end
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    checks++;
    if (pairs !== 8'd1 || mismatch !== 1'b0 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL skew_end: pairs=%0d mis=%b al=%b want 1 0 1",
               pairs, mismatch, aligned);
    end
  endtask

  task automatic test_divergence();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11);
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL div_latency: mis=%b want 0", mismatch);
    end
    tick(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
    checks++;
    if (mismatch !== 1'b1) begin
      errors++;
      $display("FAIL div_set: mis=%b want 1", mismatch);
    end
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    checks++;
    if (mismatch !== 1'b1 || pairs !== 8'd2) begin
      errors++;
      $display("FAIL div_sticky: mis=%b pairs=%0d want 1 2", mismatch, pairs);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, seq[i], 1'b1, 2'b00);
      if (i == 3) begin
        checks++;
        if (overflow !== 1'b0 || lag !== LW'(4)) begin
          errors++;
          $display("FAIL ovf_full: ovf=%b lag=%0d want 0 4", overflow, lag);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || lag !== LW'(4)) begin
      errors++;
      $display("FAIL ovf_drop: ovf=%b lag=%0d want 1 4", overflow, lag);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, seq[i]);
    end
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    checks++;
    if (pairs !== 8'd4 || aligned !== 1'b1 || mismatch !== 1'b0 ||
        overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: pairs=%0d al=%b mis=%b ovf=%b want 4 1 0 1",
               pairs, aligned, mismatch, overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11);
    tick(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00);
    tick(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00);
    tick(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00);
    checks++;
    if (mismatch !== 1'b1 || lag !== LW'(3)) begin
      errors++;
      $display("FAIL mid_setup: mis=%b lag=%0d want 1 3", mismatch, lag);
    end
    tick(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b01);
    checks++;
    if ({mismatch, overflow, aligned} !== 3'b001 || lag !== '0 ||
        pairs !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: mis=%b ovf=%b al=%b lag=%0d pairs=%0d want 0 0 1 0 0",
               mismatch, overflow, aligned, lag, pairs);
    end
    tick(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b10);
    tick(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
    tick(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
    checks++;
    if (pairs !== 8'd2 || mismatch !== 1'b0 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: pairs=%0d mis=%b al=%b want 2 0 1",
               pairs, mismatch, aligned);
    end
  endtask

  task automatic test_en_gate();
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'b11);
    tick(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00);
    tick(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01);
    checks++;
    if (pairs !== 8'd1 || lag !== LW'(1)) begin
      errors++;
      $display("FAIL en_drain: pairs=%0d lag=%0d want 1 1", pairs, lag);
    end
    tick(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01);
    checks++;
    if (pairs !== 8'd1 || lag !== LW'(1) || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL en_block: pairs=%0d lag=%0d mis=%b want 1 1 0",
               pairs, lag, mismatch);
    end
  endtask

  task automatic test_random();
    logic [LW-1:0] e_lag;
    logic [1:0] xs, xt;
    int e_p1, e_p2;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      xs = 2'($urandom_range(0, 3));
      xt = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : xs;
      tick(($urandom_range(0, 59) != 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 2) == 0), xs,
           ($urandom_range(0, 2) == 0), xt);
      e_lag = LW'(qs.size() - qt.size());
      e_p1  = (m_pairs > 255) ? 255 : m_pairs;
      e_p2  = (m_pairs > 3) ? 3 : m_pairs;
      checks++;
      if (mismatch !== m_mis || overflow !== m_ovf || lag !== e_lag ||
          aligned !== (qs.size() == 0 && qt.size() == 0) ||
          pairs !== 8'(e_p1) || pairs2 !== 2'(e_p2)) begin
        errors++;
        $display("FAIL random[%0d]: mis=%b ovf=%b lag=%0d al=%b pairs=%0d/%0d want %b %b %0d %b %0d/%0d",
                 i, mismatch, overflow, lag, aligned, pairs, pairs2,
                 m_mis, m_ovf, e_lag, (qs.size() == 0 && qt.size() == 0),
                 e_p1, e_p2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    a_src = 1'b0; b_src = 1'b0; st_src = 1'b1;
    a_tar = 1'b0; b_tar = 1'b0; st_tar = 1'b1;
    m_mis = 0; m_ovf = 0; m_pairs = 0;
    test_reset();
    test_lockstep();
    test_stutter_skew();
    test_divergence();
    test_overflow();
    test_reset_mid();
    test_en_gate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_align_checker.md
Name: trace_align_checker

Overview:
- Downstream consumer of the source/target code-block pair in the compiler-optimization case studies.
- Per side, it takes the observable outputs (a, b) and the stutter flag st, and drops stutter steps.
- Non-stutter observations are queued per side and compared pairwise in order, so the two traces are checked for stutter-equivalence.
- Sticky verdict flags (mismatch, overflow) feed the top-level property monitor as plain observable outputs.

Parameters:
- DEPTH, 4, entries per side queue (power of two, >=2).
- CNT_W, 8, width of the saturating compared-pair counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  qualifier, driven from the code-block gated-clock enable; all pushes are ignored when en=0.
- a_src  in  1  source observable a.
- b_src  in  1  source observable b.
- st_src  in  1  source stutter; 1 = non-observable step.
- a_tar  in  1  target observable a.
- b_tar  in  1  target observable b.
- st_tar  in  1  target stutter; 1 = non-observable step.
- mismatch  out  1  sticky; a compared pair differed.
- overflow  out  1  sticky; a push was dropped because a queue was full.
- aligned  out  1  both queues empty.
- lag  out  $clog2(DEPTH)+2  signed occupancy difference, src_count minus tar_count.
- pairs  out  CNT_W  number of compared pairs, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - queues emptied;
  - mismatch=0, overflow=0, pairs=0, lag=0, aligned=1.
  - Reset wins over every simultaneous event, including mid-comparison.
- Push:
  - side X pushes entry {a_X, b_X} at an edge when en=1 and st_X=0.
  - Both sides may push at the same edge.
- Pop/compare:
  - at an edge where both queue counts are >0, as seen before the edge, both heads pop together.
  - If the heads differ, mismatch is set at that same edge.
  - pairs increments at that edge and saturates at 2^CNT_W-1.
- Latency:
  - entries pushed at edge k are compared no earlier than edge k+1;
  - a mismatch therefore becomes visible after edge k+1;
  - there is no bypass path.
- Push/pop in the same edge on one side is legal; the count is unchanged.
- Full queue:
  - a push is accepted if count<DEPTH, or if that side pops at the same edge.
  - Otherwise the entry is dropped, overflow is set, and the count is unchanged.
- Empty queue: no pop; the other side keeps accumulating.
- Pointers:
  - read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH;
  - count is $clog2(DEPTH)+1 bits.
- Derived outputs:
  - lag = count_src - count_tar, sign-extended, combinational from the registered counts;
  - aligned = (count_src==0 && count_tar==0), also combinational from registered counts.
- Sticky flags: mismatch and overflow clear only on reset. The comparison continues after either is set.
- en=0:
  - no pushes;
  - pending pairs are still compared, so the queues drain;
  - flags hold.

Decomposition:
- Shared package trace_pkg holds:
  - typedef obs_t packed struct {a, b};
  - localparams for default DEPTH and CNT_W;
  - a function obs_eq.
- One sub-module, obs_fifo (parameter DEPTH, type obs_t), instantiated twice (src, tar):
  - ports push, push_data, pop, head, count, full, empty;
  - internal push-when-full-with-pop handling.
- The top holds the pair/pop logic, the flags, the counter, lag and aligned.

Test Plan:
- Lockstep: en=1, st_src=st_tar=0 for 5 cycles with identical (a,b) sequence 00,01,10,11,00 -> pairs=5, mismatch=0, aligned=1 two edges after the last push.
- Stutter skew: src emits 01 then stutters 3 cycles; tar stutters 2 cycles, then emits 01 -> lag peaks at +1, returns to 0; mismatch=0, pairs=1.
- Divergence: src pushes 10, tar pushes 11 at the same edge k -> mismatch=1 after edge k+1 and stays 1; later equal pairs do not clear it.
- Overflow: tar stutters while src pushes DEPTH+1=5 entries -> overflow=1 on the 5th push, lag=+4. Then tar pushes 4 matching entries -> pairs=4, aligned=1.
- Reset mid-operation: src holds 3 pending entries, mismatch=1; rst_n=0 for one edge -> all outputs at reset values. The next matched pushes compare correctly from empty.
- Saturation: CNT_W=2, 5 lockstep matching pairs -> pairs holds at 3; en=0 blocks new pushes while pending pairs still drain.
